// File: rtl/branch_unit_pkg.sv
// Branch funct3 encodings and decode helpers shared by the branch unit
// and any later consumer of the compare core.
package branch_unit_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  function automatic logic br_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic       eq,
    input logic       lt,
    input logic       ltu
  );
    logic t;
    t = 1'b0;
    unique case (f3)
      BR_EQ:   t = eq;
      BR_NE:   t = ~eq;
      BR_LT:   t = lt;
      BR_GE:   t = ~lt;
      BR_LTU:  t = ltu;
      BR_GEU:  t = ~ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_unit_cmp_core.sv
// Combinational WIDTH-bit equality, signed and unsigned less-than.
// Pure logic so the hazard unit can reuse it directly.
module branch_cmp_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  assign eq  = (a == b);
  assign ltu = (a < b);
  // Differing signs: the negative operand is smaller.
  assign lt  = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : ltu;

endmodule

// File: rtl/branch_unit.sv
// Pipelined branch resolve with mispredict flag, LATENCY 1 or 2.
// Optional saturating counters under `BRANCH_PERF_CNT_EN.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LATENCY   = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             pred_taken,
  output logic             out_valid,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal,
  output logic             breq,
  output logic             brlt,
  output logic             brltu
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_branch,
  output logic [CNT_WIDTH-1:0] cnt_taken,
  output logic [CNT_WIDTH-1:0] cnt_mispred
`endif
);

  logic       c_eq, c_lt, c_ltu;
  logic       d_valid, d_eq, d_lt, d_ltu, d_pred;
  logic [2:0] d_f3;

  branch_cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .a   (rs1),
    .b   (rs2),
    .eq  (c_eq),
    .lt  (c_lt),
    .ltu (c_ltu)
  );

  generate
    if (LATENCY == 2) begin : g_s1
      logic       s1_valid, s1_eq, s1_lt, s1_ltu, s1_pred;
      logic [2:0] s1_f3;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_eq    <= 1'b0;
          s1_lt    <= 1'b0;
          s1_ltu   <= 1'b0;
          s1_pred  <= 1'b0;
          s1_f3    <= 3'b000;
        end else if (flush) begin
          s1_valid <= 1'b0;
        end else if (!stall) begin
          s1_valid <= in_valid;
          s1_eq    <= c_eq;
          s1_lt    <= c_lt;
          s1_ltu   <= c_ltu;
          s1_pred  <= pred_taken;
          s1_f3    <= funct3;
        end
      end

      assign d_valid = s1_valid;
      assign d_eq    = s1_eq;
      assign d_lt    = s1_lt;
      assign d_ltu   = s1_ltu;
      assign d_pred  = s1_pred;
      assign d_f3    = s1_f3;
    end else begin : g_s0
      assign d_valid = in_valid;
      assign d_eq    = c_eq;
      assign d_lt    = c_lt;
      assign d_ltu   = c_ltu;
      assign d_pred  = pred_taken;
      assign d_f3    = funct3;
    end
  endgenerate

  logic d_taken, d_ill;
  logic v_q, tk_q, mp_q, il_q, eq_q, lt_q, ltu_q;

  assign d_taken = br_taken(d_f3, d_eq, d_lt, d_ltu);
  assign d_ill   = br_illegal(d_f3);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      tk_q  <= 1'b0;
      mp_q  <= 1'b0;
      il_q  <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      ltu_q <= 1'b0;
    end else if (flush) begin
      v_q   <= 1'b0;
    end else if (!stall) begin
      v_q   <= d_valid;
      tk_q  <= d_taken;
      mp_q  <= ~d_ill & (d_taken ^ d_pred);
      il_q  <= d_ill;
      eq_q  <= d_eq;
      lt_q  <= d_lt;
      ltu_q <= d_ltu;
    end
  end

  // Decision outputs read as zero in bubbles.
  assign out_valid  = v_q;
  assign taken      = v_q & tk_q;
  assign mispredict = v_q & mp_q;
  assign illegal    = v_q & il_q;
  assign breq       = eq_q;
  assign brlt       = lt_q;
  assign brltu      = ltu_q;

`ifdef BRANCH_PERF_CNT_EN
  logic cnt_en;
  assign cnt_en = v_q & ~stall & ~il_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch  <= '0;
      cnt_taken   <= '0;
      cnt_mispred <= '0;
    end else if (cnt_en) begin
      if (cnt_branch != '1)
        cnt_branch <= cnt_branch + 1'b1;
      if (tk_q && cnt_taken != '1)
        cnt_taken <= cnt_taken + 1'b1;
      if (mp_q && cnt_mispred != '1)
        cnt_mispred <= cnt_mispred + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench: LATENCY=1 and LATENCY=2 instances share one stimulus.
// Counter checks compile only with `BRANCH_PERF_CNT_EN.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, pred_taken;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;

  logic o1_v, o1_t, o1_m, o1_i, o1_eq, o1_lt, o1_ltu;
  logic o2_v, o2_t, o2_m, o2_i, o2_eq, o2_lt, o2_ltu;
`ifdef BRANCH_PERF_CNT_EN
  logic [3:0]  c1_b, c1_t, c1_m;
  logic [31:0] c2_b, c2_t, c2_m;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_unit #(.WIDTH(32), .LATENCY(1), .CNT_WIDTH(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .flush(flush), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .pred_taken(pred_taken), .out_valid(o1_v), .taken(o1_t),
    .mispredict(o1_m), .illegal(o1_i), .breq(o1_eq),
    .brlt(o1_lt), .brltu(o1_ltu)
`ifdef BRANCH_PERF_CNT_EN
    , .cnt_branch(c1_b), .cnt_taken(c1_t), .cnt_mispred(c1_m)
`endif
  );

  branch_unit #(.WIDTH(32), .LATENCY(2), .CNT_WIDTH(32)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
    .flush(flush), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .pred_taken(pred_taken), .out_valid(o2_v), .taken(o2_t),
    .mispredict(o2_m), .illegal(o2_i), .breq(o2_eq),
    .brlt(o2_lt), .brltu(o2_ltu)
`ifdef BRANCH_PERF_CNT_EN
    , .cnt_branch(c2_b), .cnt_taken(c2_t), .cnt_mispred(c2_m)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic p);
    in_valid   = v;
    funct3     = f;
    rs1        = a;
    rs2        = b;
    pred_taken = p;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_v1", {31'b0, o1_v}, 32'd0);
    chk("rst_v2", {31'b0, o2_v}, 32'd0);
    chk("rst_t1", {31'b0, o1_t}, 32'd0);
    chk("rst_eq2", {31'b0, o2_eq}, 32'd0);

    // BLT -1 < 1, predicted not taken
    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    chk("blt_v1", {31'b0, o1_v}, 32'd1);
    chk("blt_t1", {31'b0, o1_t}, 32'd1);
    chk("blt_m1", {31'b0, o1_m}, 32'd1);
    chk("blt_lt1", {31'b0, o1_lt}, 32'd1);
    chk("blt_ltu1", {31'b0, o1_ltu}, 32'd0);
    chk("blt_v2_early", {31'b0, o2_v}, 32'd0);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    tick();
    chk("blt_v2", {31'b0, o2_v}, 32'd1);
    chk("blt_t2", {31'b0, o2_t}, 32'd1);
    chk("blt_m2", {31'b0, o2_m}, 32'd1);
    chk("bub_v1", {31'b0, o1_v}, 32'd0);
    chk("bub_t1", {31'b0, o1_t}, 32'd0);
    chk("bub_m1", {31'b0, o1_m}, 32'd0);
    tick();

    // Back-to-back BEQ, BNE, BGEU
    drive(1'b1, 3'b000, 32'd5, 32'd5, 1'b1);
    tick();
    chk("b2b_beq_t1", {31'b0, o1_t}, 32'd1);
    chk("b2b_beq_m1", {31'b0, o1_m}, 32'd0);
    chk("b2b_beq_v2n", {31'b0, o2_v}, 32'd0);
    drive(1'b1, 3'b001, 32'd5, 32'd5, 1'b1);
    tick();
    chk("b2b_bne_t1", {31'b0, o1_t}, 32'd0);
    chk("b2b_bne_m1", {31'b0, o1_m}, 32'd1);
    chk("b2b_beq_v2", {31'b0, o2_v}, 32'd1);
    chk("b2b_beq_t2", {31'b0, o2_t}, 32'd1);
    drive(1'b1, 3'b111, 32'h8000_0000, 32'd1, 1'b0);
    tick();
    chk("b2b_bgeu_t1", {31'b0, o1_t}, 32'd1);
    chk("b2b_bne_v2", {31'b0, o2_v}, 32'd1);
    chk("b2b_bne_t2", {31'b0, o2_t}, 32'd0);
    chk("b2b_bne_m2", {31'b0, o2_m}, 32'd1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    tick();
    chk("b2b_bgeu_v2", {31'b0, o2_v}, 32'd1);
    chk("b2b_bgeu_t2", {31'b0, o2_t}, 32'd1);
    chk("b2b_bgeu_m2", {31'b0, o2_m}, 32'd1);
    tick();
    chk("b2b_end_v2", {31'b0, o2_v}, 32'd0);

    // Stall for three cycles with a branch in flight
    drive(1'b1, 3'b110, 32'd1, 32'd2, 1'b1);
    tick();
    chk("stl_v1", {31'b0, o1_v}, 32'd1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_hold_v1", {31'b0, o1_v}, 32'd1);
      chk("stl_hold_t1", {31'b0, o1_t}, 32'd1);
      chk("stl_hold_v2", {31'b0, o2_v}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("stl_rel_v1", {31'b0, o1_v}, 32'd0);
    chk("stl_rel_v2", {31'b0, o2_v}, 32'd1);
    chk("stl_rel_t2", {31'b0, o2_t}, 32'd1);
    chk("stl_rel_m2", {31'b0, o2_m}, 32'd0);
    tick();
    chk("stl_once_v2", {31'b0, o2_v}, 32'd0);

    // Flush together with stall, two entries in flight on u2
    drive(1'b1, 3'b000, 32'd1, 32'd1, 1'b0);
    tick();
    drive(1'b1, 3'b001, 32'd1, 32'd2, 1'b0);
    tick();
    chk("fl_pre_v2", {31'b0, o2_v}, 32'd1);
    drive(1'b1, 3'b000, 32'd3, 32'd3, 1'b0);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    chk("fl_v1", {31'b0, o1_v}, 32'd0);
    chk("fl_v2", {31'b0, o2_v}, 32'd0);
    chk("fl_t2", {31'b0, o2_t}, 32'd0);
    tick();
    chk("fl_late_v2a", {31'b0, o2_v}, 32'd0);
    chk("fl_late_v1", {31'b0, o1_v}, 32'd0);
    tick();
    chk("fl_late_v2b", {31'b0, o2_v}, 32'd0);

    // Illegal funct3 with equal operands
    drive(1'b1, 3'b010, 32'd7, 32'd7, 1'b1);
    tick();
    chk("ill_v1", {31'b0, o1_v}, 32'd1);
    chk("ill_i1", {31'b0, o1_i}, 32'd1);
    chk("ill_t1", {31'b0, o1_t}, 32'd0);
    chk("ill_m1", {31'b0, o1_m}, 32'd0);
    drive(1'b1, 3'b011, 32'd7, 32'd8, 1'b0);
    tick();
    chk("ill_i2", {31'b0, o2_i}, 32'd1);
    chk("ill_t2", {31'b0, o2_t}, 32'd0);
    chk("ill_m2", {31'b0, o2_m}, 32'd0);
    chk("ill011_i1", {31'b0, o1_i}, 32'd1);

    // Width boundaries
    drive(1'b1, 3'b101, 32'h8000_0000, 32'h0, 1'b1);
    tick();
    chk("msb_lt1", {31'b0, o1_lt}, 32'd1);
    chk("msb_ltu1", {31'b0, o1_ltu}, 32'd0);
    chk("msb_bge_t1", {31'b0, o1_t}, 32'd0);
    chk("msb_bge_m1", {31'b0, o1_m}, 32'd1);
    chk("msb_i1", {31'b0, o1_i}, 32'd0);
    drive(1'b1, 3'b111, 32'h1234_5678, 32'h1234_5678, 1'b1);
    tick();
    chk("eqop_eq1", {31'b0, o1_eq}, 32'd1);
    chk("eqop_lt1", {31'b0, o1_lt}, 32'd0);
    chk("eqop_ltu1", {31'b0, o1_ltu}, 32'd0);
    chk("eqop_t1", {31'b0, o1_t}, 32'd1);
    chk("msb_lt2", {31'b0, o2_lt}, 32'd1);
    chk("msb_ltu2", {31'b0, o2_ltu}, 32'd0);
    drive(1'b1, 3'b100, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
    tick();
    chk("neg_lt1", {31'b0, o1_lt}, 32'd1);
    chk("neg_ltu1", {31'b0, o1_ltu}, 32'd1);
    chk("neg_t1", {31'b0, o1_t}, 32'd1);
    chk("neg_m1", {31'b0, o1_m}, 32'd0);
    drive(1'b1, 3'b110, 32'h0, 32'h8000_0000, 1'b0);
    tick();
    chk("u_lt1", {31'b0, o1_lt}, 32'd0);
    chk("u_ltu1", {31'b0, o1_ltu}, 32'd1);
    chk("u_bltu_t1", {31'b0, o1_t}, 32'd1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    tick(); tick();

`ifdef BRANCH_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_rst_b", {28'b0, c1_b}, 32'd0);
    drive(1'b1, 3'b010, 32'd1, 32'd1, 1'b0);
    tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    tick();
    chk("cnt_ill_b", {28'b0, c1_b}, 32'd0);
    drive(1'b1, 3'b000, 32'd9, 32'd9, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    chk("cnt_sat_b", {28'b0, c1_b}, 32'hF);
    chk("cnt_sat_t", {28'b0, c1_t}, 32'hF);
    chk("cnt_sat_m", {28'b0, c1_m}, 32'hF);
    chk("cnt2_b", c2_b, 32'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt_clr_b", {28'b0, c1_b}, 32'd0);
    chk("cnt_clr_t", {28'b0, c1_t}, 32'd0);
    chk("cnt_clr_m", {28'b0, c1_m}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
